// File: rtl/usb_cdc_fifo_bridge.sv
// Buffered byte bridge between the usb_cdc core and user logic: RX/TX FIFOs gated by USB configuration.
// Optional macro USB_CDC_BRIDGE_LOOPBACK_EN adds loopback_i (RX FIFO output feeds TX FIFO input).

// bridge_fifo: first-word-fall-through FIFO with synchronous clear.
// Latency: a write is visible at the read side one cycle later.
// Backpressure: wr_rdy_o = !full; a full FIFO refuses a push even when popped in the same cycle.
module bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       wr_vld_i,
  input  logic [W-1:0]               wr_dat_i,
  output logic                       wr_rdy_o,
  output logic                       rd_vld_o,
  output logic [W-1:0]               rd_dat_o,
  input  logic                       rd_rdy_i,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [LW-1:0] wr_cnt_q, wr_cnt_d;
  logic [LW-1:0] rd_cnt_q, rd_cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          full;
  logic          push;
  logic          pop;

  assign level_o  = wr_cnt_q - rd_cnt_q;
  assign full     = (level_o == FULL_LVL);
  assign wr_rdy_o = ~full;
  assign rd_vld_o = (level_o != '0);
  assign rd_dat_o = mem_q[rd_cnt_q[AW-1:0]];
  assign push     = wr_vld_i & ~full & ~clr_i;
  assign pop      = rd_vld_o & rd_rdy_i & ~clr_i;

  always_comb begin
    mem_d    = mem_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (clr_i) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_cnt_q[AW-1:0]] = wr_dat_i;
        wr_cnt_d = wr_cnt_q + LW'(1);
      end
      if (pop) begin
        rd_cnt_d = rd_cnt_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
endmodule

// usb_cdc_fifo_bridge: RX (host->device) and TX (device->host) FIFOs, flush, levels, TX drop counter.
// Latency: one cycle from any accepted byte to its appearance on the far side.
// Backpressure: readies are !full from registered state; unconfigured RX discards, TX drops or stalls.
module usb_cdc_fifo_bridge #(
  parameter int DATA_W         = 8,
  parameter int RX_DEPTH       = 16,
  parameter int TX_DEPTH       = 16,
  parameter int TX_DROP_UNCONF = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        configured_i,
`ifdef USB_CDC_BRIDGE_LOOPBACK_EN
  input  logic                        loopback_i,
`endif
  input  logic                        flush_i,
  input  logic [DATA_W-1:0]           usb_out_data_i,
  input  logic                        usb_out_valid_i,
  output logic                        usb_out_ready_o,
  output logic [DATA_W-1:0]           usb_in_data_o,
  output logic                        usb_in_valid_o,
  input  logic                        usb_in_ready_i,
  output logic [DATA_W-1:0]           app_rx_data_o,
  output logic                        app_rx_valid_o,
  input  logic                        app_rx_ready_i,
  input  logic [DATA_W-1:0]           app_tx_data_i,
  input  logic                        app_tx_valid_i,
  output logic                        app_tx_ready_o,
  output logic [$clog2(RX_DEPTH):0]   rx_level_o,
  output logic [$clog2(TX_DEPTH):0]   tx_level_o,
  output logic [7:0]                  drop_cnt_o
);
  localparam logic DROP_EN = (TX_DROP_UNCONF != 0);

  logic                        clr;
  logic                        lb_q;
  logic                        rx_wr_rdy, rx_rd_vld, rx_rd_rdy;
  logic [DATA_W-1:0]           rx_rd_dat;
  logic [$clog2(RX_DEPTH):0]   rx_level;
  logic                        tx_wr_vld, tx_wr_rdy, tx_rd_vld;
  logic [DATA_W-1:0]           tx_wr_dat, tx_rd_dat;
  logic [$clog2(TX_DEPTH):0]   tx_level;
  logic [7:0]                  drop_cnt_q, drop_cnt_d;

  // Losing configuration is treated exactly like a flush of both directions.
  assign clr = flush_i | ~configured_i;

`ifdef USB_CDC_BRIDGE_LOOPBACK_EN
  logic lb_d;

  always_comb begin
    lb_d = loopback_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lb_q <= 1'b0;
    end else begin
      lb_q <= lb_d;
    end
  end
`else
  assign lb_q = 1'b0;
`endif

  bridge_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr),
    .wr_vld_i (usb_out_valid_i),
    .wr_dat_i (usb_out_data_i),
    .wr_rdy_o (rx_wr_rdy),
    .rd_vld_o (rx_rd_vld),
    .rd_dat_o (rx_rd_dat),
    .rd_rdy_i (rx_rd_rdy),
    .level_o  (rx_level)
  );

  // In loopback the RX head moves into TX whenever TX has room.
  assign rx_rd_rdy = lb_q ? tx_wr_rdy : app_rx_ready_i;
  assign tx_wr_vld = lb_q ? rx_rd_vld : app_tx_valid_i;
  assign tx_wr_dat = lb_q ? rx_rd_dat : app_tx_data_i;

  bridge_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr),
    .wr_vld_i (tx_wr_vld),
    .wr_dat_i (tx_wr_dat),
    .wr_rdy_o (tx_wr_rdy),
    .rd_vld_o (tx_rd_vld),
    .rd_dat_o (tx_rd_dat),
    .rd_rdy_i (usb_in_ready_i),
    .level_o  (tx_level)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (DROP_EN && !configured_i && !lb_q && app_tx_valid_i && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign usb_out_ready_o = ~rst_i & (~configured_i | rx_wr_rdy);
  assign usb_in_valid_o  = ~rst_i & configured_i & tx_rd_vld;
  assign usb_in_data_o   = tx_rd_dat;
  assign app_rx_valid_o  = ~rst_i & configured_i & ~lb_q & rx_rd_vld;
  assign app_rx_data_o   = rx_rd_dat;
  assign app_tx_ready_o  = ~rst_i & ~lb_q & (configured_i ? tx_wr_rdy : DROP_EN);
  assign rx_level_o      = rst_i ? '0 : rx_level;
  assign tx_level_o      = rst_i ? '0 : tx_level;
  assign drop_cnt_o      = rst_i ? 8'd0 : drop_cnt_q;
endmodule

// File: tb/tb_usb_cdc_fifo_bridge.sv
// Scoreboard bench for usb_cdc_fifo_bridge: queues filled at accepted pushes, checked at pops.
module tb_usb_cdc_fifo_bridge;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg = 1'b0;
  logic       lb = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] uo_dat = 8'h00;
  logic       uo_vld = 1'b0;
  logic       ui_rdy = 1'b0;
  logic       ar_rdy = 1'b0;
  logic [7:0] at_dat = 8'h00;
  logic       at_vld = 1'b0;

  logic [7:0] ui_dat, ar_dat, drop_cnt, drop_cnt_st;
  logic       uo_rdy, ui_vld, ar_vld, at_rdy;
  logic       uo_rdy_st, ui_vld_st, ar_vld_st, at_rdy_st;
  logic [7:0] ui_dat_st, ar_dat_st;
  logic [4:0] rx_lvl, tx_lvl, rx_lvl_st, tx_lvl_st;

  int checks = 0;
  int errors = 0;
  int rx_pops = 0;
  int drop_exp = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  usb_cdc_fifo_bridge #(.DATA_W(8), .RX_DEPTH(16), .TX_DEPTH(16), .TX_DROP_UNCONF(1)) dut (
    .clk_i(clk), .rst_i(rst), .configured_i(cfg),
`ifdef USB_CDC_BRIDGE_LOOPBACK_EN
    .loopback_i(lb),
`endif
    .flush_i(flush),
    .usb_out_data_i(uo_dat), .usb_out_valid_i(uo_vld), .usb_out_ready_o(uo_rdy),
    .usb_in_data_o(ui_dat), .usb_in_valid_o(ui_vld), .usb_in_ready_i(ui_rdy),
    .app_rx_data_o(ar_dat), .app_rx_valid_o(ar_vld), .app_rx_ready_i(ar_rdy),
    .app_tx_data_i(at_dat), .app_tx_valid_i(at_vld), .app_tx_ready_o(at_rdy),
    .rx_level_o(rx_lvl), .tx_level_o(tx_lvl), .drop_cnt_o(drop_cnt)
  );

  // Stalling variant: only its app TX ready is of interest.
  usb_cdc_fifo_bridge #(.DATA_W(8), .RX_DEPTH(16), .TX_DEPTH(16), .TX_DROP_UNCONF(0)) dut_st (
    .clk_i(clk), .rst_i(rst), .configured_i(cfg),
`ifdef USB_CDC_BRIDGE_LOOPBACK_EN
    .loopback_i(1'b0),
`endif
    .flush_i(flush),
    .usb_out_data_i(uo_dat), .usb_out_valid_i(uo_vld), .usb_out_ready_o(uo_rdy_st),
    .usb_in_data_o(ui_dat_st), .usb_in_valid_o(ui_vld_st), .usb_in_ready_i(ui_rdy),
    .app_rx_data_o(ar_dat_st), .app_rx_valid_o(ar_vld_st), .app_rx_ready_i(ar_rdy),
    .app_tx_data_i(at_dat), .app_tx_valid_i(at_vld), .app_tx_ready_o(at_rdy_st),
    .rx_level_o(rx_lvl_st), .tx_level_o(tx_lvl_st), .drop_cnt_o(drop_cnt_st)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change just after posedge, so at negedge they show what the next edge will sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (ar_vld && ar_rdy) begin
        rx_pops++;
        if (rx_q.size() == 0) chk("rx_spurious", 32'(ar_dat), 32'hFFFF_FFFF);
        else chk("rx_data", 32'(ar_dat), 32'(rx_q.pop_front()));
      end
      if (ui_vld && ui_rdy) begin
        if (tx_q.size() == 0) chk("tx_spurious", 32'(ui_dat), 32'hFFFF_FFFF);
        else chk("tx_data", 32'(ui_dat), 32'(tx_q.pop_front()));
      end
      if (flush || !cfg) begin
        rx_q.delete();
        tx_q.delete();
      end else begin
        if (uo_vld && uo_rdy) begin
          if (lb) tx_q.push_back(uo_dat);
          else rx_q.push_back(uo_dat);
        end
        if (at_vld && at_rdy) tx_q.push_back(at_dat);
      end
      if (!cfg && !lb && at_vld && at_rdy && drop_exp < 255) drop_exp++;
    end
  end

  task automatic drain(input string tag);
    ar_rdy = 1'b1;
    ui_rdy = 1'b1;
    for (int i = 0; i < 60 && (rx_q.size() != 0 || tx_q.size() != 0); i++) tick();
    chk({tag, "_rx_left"}, 32'(rx_q.size()), 0);
    chk({tag, "_tx_left"}, 32'(tx_q.size()), 0);
    ar_rdy = 1'b0;
    ui_rdy = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic uo_acc, at_acc;
    // Reset
    repeat (3) tick();
    chk("rst_uo_rdy", 32'(uo_rdy), 0);
    chk("rst_at_rdy", 32'(at_rdy), 0);
    chk("rst_ar_vld", 32'(ar_vld), 0);
    chk("rst_ui_vld", 32'(ui_vld), 0);
    chk("rst_rx_lvl", 32'(rx_lvl), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst = 1'b0;
    cfg = 1'b1;
    tick();
    chk("cfg_uo_rdy", 32'(uo_rdy), 1);
    chk("cfg_ar_vld", 32'(ar_vld), 0);
    chk("cfg_levels", 32'({rx_lvl, tx_lvl}), 0);

    // Single byte, one-cycle visibility
    uo_vld = 1'b1; uo_dat = 8'hA5;
    tick();
    uo_vld = 1'b0;
    chk("a5_vld", 32'(ar_vld), 1);
    chk("a5_dat", 32'(ar_dat), 32'hA5);
    chk("a5_lvl", 32'(rx_lvl), 1);
    drain("a5");

    // RX fill to 16, refused 17th, in-order drain
    for (int i = 0; i < 16; i++) begin
      uo_vld = 1'b1; uo_dat = 8'(i);
      tick();
    end
    uo_dat = 8'h77;
    chk("rx_full_lvl", 32'(rx_lvl), 16);
    chk("rx_full_rdy", 32'(uo_rdy), 0);
    tick();
    uo_vld = 1'b0;
    chk("rx_full_hold", 32'(rx_lvl), 16);
    base = rx_pops;
    drain("rx16");
    chk("rx16_pops", 32'(rx_pops - base), 16);
    chk("rx16_lvl", 32'(rx_lvl), 0);

    // TX full: simultaneous push refused while pop proceeds, retried next cycle
    for (int i = 0; i < 16; i++) begin
      at_vld = 1'b1; at_dat = 8'(8'h40 + i);
      tick();
    end
    at_dat = 8'h99;
    chk("tx_full_lvl", 32'(tx_lvl), 16);
    chk("tx_full_rdy", 32'(at_rdy), 0);
    ui_rdy = 1'b1;
    tick();
    ui_rdy = 1'b0;
    chk("tx_refused_lvl", 32'(tx_lvl), 15);
    chk("tx_retry_rdy", 32'(at_rdy), 1);
    tick();
    at_vld = 1'b0;
    chk("tx_retry_lvl", 32'(tx_lvl), 16);
    drain("tx16");

    // Flush and deconfigure from levels 5/3
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        uo_vld = 1'b1; uo_dat = 8'(8'hC0 + i);
        at_vld = (i < 3); at_dat = 8'(8'hD0 + i);
        tick();
      end
      uo_vld = 1'b0; at_vld = 1'b0;
      chk("pre_clr_rx", 32'(rx_lvl), 5);
      chk("pre_clr_tx", 32'(tx_lvl), 3);
      if (pass == 0) flush = 1'b1; else cfg = 1'b0;
      tick();
      flush = 1'b0;
      chk("clr_rx_lvl", 32'(rx_lvl), 0);
      chk("clr_tx_lvl", 32'(tx_lvl), 0);
      chk("clr_ui_vld", 32'(ui_vld), 0);
      chk("clr_uo_rdy", 32'(uo_rdy), 1);
      cfg = 1'b1;
      tick();
      chk("reconf_ar_vld", 32'(ar_vld), 0);
      chk("reconf_ui_vld", 32'(ui_vld), 0);
    end

    // Unconfigured TX: drop (saturating) vs stall
    cfg = 1'b0;
    at_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      at_dat = 8'(i);
      #1;
      chk("drop_rdy", 32'(at_rdy), 1);
      chk("stall_rdy", 32'(at_rdy_st), 0);
      tick();
      chk("drop_ui_vld", 32'(ui_vld), 0);
      if (i == 99) chk("drop_100", 32'(drop_cnt), 100);
    end
    at_vld = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 255);
    chk("drop_model", 32'(drop_cnt), 32'(drop_exp));
    cfg = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drop_after_flush", 32'(drop_cnt), 255);

    // Random concurrent traffic
    uo_acc = 1'b1;
    at_acc = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (!uo_vld || uo_acc) begin
        uo_vld = 1'($urandom_range(0, 1)); uo_dat = 8'($urandom);
      end
      if (!at_vld || at_acc) begin
        at_vld = 1'($urandom_range(0, 1)); at_dat = 8'($urandom);
      end
      ar_rdy = ($urandom_range(0, 3) != 0);
      ui_rdy = ($urandom_range(0, 3) == 0);
      #1;
      uo_acc = uo_vld && uo_rdy;
      at_acc = at_vld && at_rdy;
      tick();
    end
    uo_vld = 1'b0; at_vld = 1'b0;
    drain("rand");
    chk("rand_lvls", 32'({rx_lvl, tx_lvl}), 0);

`ifdef USB_CDC_BRIDGE_LOOPBACK_EN
    lb = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      uo_vld = 1'b1; uo_dat = 8'(8'h11 * (i + 1));
      tick();
      chk("lb_ar_vld", 32'(ar_vld), 0);
    end
    uo_vld = 1'b0;
    repeat (4) tick();
    chk("lb_ar_vld_idle", 32'(ar_vld), 0);
    chk("lb_at_rdy", 32'(at_rdy), 0);
    chk("lb_tx_lvl", 32'(tx_lvl), 3);
    drain("lb");
    lb = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
